uart_fifo_core: RTL and testbench

UART_FIFO_CORE -- requirements
Module: uart_fifo_core

---
 rtl/uart_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 49 ++++
 rtl/uart_fifo_core.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART FIFO core: FSM states and
// data-length arithmetic used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // data_len encodes (bits - DATA_BITS_BASE), so 0..3 maps to 5..8 data bits
  localparam int unsigned DATA_BITS_BASE = 5;

  function automatic logic [7:0] data_mask(input logic [1:0] len);
    return 8'hFF >> (2'd3 - len);
  endfunction

  function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
    return {1'b0, len} + 3'(DATA_BITS_BASE - 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a write into a full FIFO is
// accepted only when a read frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; empty pointers make its contents
  // unobservable, and leaving it unreset keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_fifo_core.sv
// UART transmitter and receiver with per-direction baud tick generators,
// runtime frame format, and FIFO buffering on both sides.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_len,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_sn,
  output logic             tx_busy,
  input  logic             rx_sn,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_frame_err,
  output logic             rx_parity_err,
  output logic             rx_overrun,
  input  logic             err_clr
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

  // ---------------- transmit path ----------------
  logic             tx_fifo_full;
  logic             tx_fifo_empty;
  logic [7:0]       tx_fifo_data;
  logic             tx_pop;
  tx_state_e        tx_state;
  tx_state_e        tx_state_n;
  logic [DIV_W-1:0] tx_div_cnt;
  logic [OS_W-1:0]  tx_os_cnt;
  logic [2:0]       tx_bit_cnt;
  logic             tx_stop_cnt;
  logic [7:0]       tx_shift;
  logic             tx_par;
  logic [1:0]       tx_cfg_len;
  logic             tx_cfg_par_en;
  logic             tx_cfg_stop2;
  logic             tx_tick;
  logic             tx_bit_end;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_valid && tx_ready),
    .wr_data (tx_data),
    .rd_en   (tx_pop),
    .rd_data (tx_fifo_data),
    .full    (tx_fifo_full),
    .empty   (tx_fifo_empty)
  );

  assign tx_ready   = !tx_fifo_full;
  assign tx_busy    = (tx_state != TX_IDLE) || !tx_fifo_empty;
  assign tx_tick    = (tx_div_cnt == baud_div);
  assign tx_bit_end = tx_tick && (tx_os_cnt == OS_LAST);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    tx_state_n = tx_state;
    tx_pop     = 1'b0;
    tx_sn      = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_fifo_empty) begin
          tx_pop     = 1'b1;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        tx_sn = 1'b0;
        if (tx_bit_end) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        tx_sn = tx_shift[0];
        if (tx_bit_end && (tx_bit_cnt == last_bit_idx(tx_cfg_len)))
          tx_state_n = tx_cfg_par_en ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx_sn = tx_par;
        if (tx_bit_end) tx_state_n = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end && (tx_stop_cnt || !tx_cfg_stop2)) tx_state_n = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state      <= TX_IDLE;
      tx_div_cnt    <= '0;
      tx_os_cnt     <= '0;
      tx_bit_cnt    <= '0;
      tx_stop_cnt   <= 1'b0;
      tx_shift      <= '0;
      tx_par        <= 1'b0;
      tx_cfg_len    <= '0;
      tx_cfg_par_en <= 1'b0;
      tx_cfg_stop2  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      if (tx_state == TX_IDLE) begin
        // Counters sit at zero so the first bit of a frame is a full bit time
        tx_div_cnt  <= '0;
        tx_os_cnt   <= '0;
        tx_bit_cnt  <= '0;
        tx_stop_cnt <= 1'b0;
        if (tx_pop) begin
          tx_shift      <= tx_fifo_data & data_mask(data_len);
          tx_par        <= ^(tx_fifo_data & data_mask(data_len)) ^ parity_odd;
          tx_cfg_len    <= data_len;
          tx_cfg_par_en <= parity_en;
          tx_cfg_stop2  <= stop2;
        end
      end else begin
        tx_div_cnt <= tx_tick ? '0 : tx_div_cnt + 1'b1;
        if (tx_tick) tx_os_cnt <= (tx_os_cnt == OS_LAST) ? '0 : tx_os_cnt + 1'b1;
        if (tx_bit_end && (tx_state == TX_DATA)) begin
          tx_shift   <= tx_shift >> 1;
          tx_bit_cnt <= tx_bit_cnt + 1'b1;
        end
        if (tx_bit_end && (tx_state == TX_STOP)) tx_stop_cnt <= 1'b1;
      end
    end
  end

  // ---------------- receive path ----------------
  logic             rx_meta;
  logic             rx_s;
  rx_state_e        rx_state;
  rx_state_e        rx_state_n;
  logic [DIV_W-1:0] rx_div_cnt;
  logic [OS_W-1:0]  rx_os_cnt;
  logic [2:0]       rx_bit_cnt;
  logic [7:0]       rx_shift;
  logic             rx_pbit;
  logic [1:0]       rx_cfg_len;
  logic             rx_cfg_par_en;
  logic             rx_cfg_odd;
  logic             rx_tick;
  logic             rx_half;
  logic             rx_centre;
  logic             rx_push;
  logic             rx_pop;
  logic [9:0]       rx_word;
  logic [9:0]       rx_head;
  logic             rx_fifo_full;
  logic             rx_fifo_empty;

  assign rx_tick   = (rx_div_cnt == baud_div);
  assign rx_half   = rx_tick && (rx_os_cnt == OS_HALF);
  assign rx_centre = rx_tick && (rx_os_cnt == OS_LAST);

  // Word layout in the FIFO: {parity_err, frame_err, data}
  assign rx_word = {rx_cfg_par_en && ((^rx_shift ^ rx_pbit) != rx_cfg_odd), !rx_s, rx_shift};

  always_comb begin
    rx_state_n = rx_state;
    rx_push    = 1'b0;
    case (rx_state)
      RX_IDLE:   if (!rx_s) rx_state_n = RX_START;
      RX_START:  if (rx_half) rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (rx_centre && (rx_bit_cnt == last_bit_idx(rx_cfg_len)))
          rx_state_n = rx_cfg_par_en ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_centre) rx_state_n = RX_STOP;
      RX_STOP: begin
        if (rx_centre) begin
          rx_push    = 1'b1;
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_div_cnt    <= '0;
      rx_os_cnt     <= '0;
      rx_bit_cnt    <= '0;
      rx_shift      <= '0;
      rx_pbit       <= 1'b0;
      rx_cfg_len    <= '0;
      rx_cfg_par_en <= 1'b0;
      rx_cfg_odd    <= 1'b0;
    end else begin
      rx_meta  <= rx_sn;
      rx_s     <= rx_meta;
      rx_state <= rx_state_n;
      if (rx_state == RX_IDLE) begin
        rx_div_cnt <= '0;
        rx_os_cnt  <= '0;
        rx_bit_cnt <= '0;
        if (!rx_s) begin
          rx_shift      <= '0;
          rx_cfg_len    <= data_len;
          rx_cfg_par_en <= parity_en;
          rx_cfg_odd    <= parity_odd;
        end
      end else begin
        rx_div_cnt <= rx_tick ? '0 : rx_div_cnt + 1'b1;
        // After the start-bit midpoint the phase restarts so later samples land at bit centres
        if ((rx_state == RX_START) && rx_half)
          rx_os_cnt <= '0;
        else if (rx_tick)
          rx_os_cnt <= (rx_os_cnt == OS_LAST) ? '0 : rx_os_cnt + 1'b1;
        if (rx_centre && (rx_state == RX_DATA)) begin
          rx_shift[rx_bit_cnt] <= rx_s;
          rx_bit_cnt           <= rx_bit_cnt + 1'b1;
        end
        if (rx_centre && (rx_state == RX_PARITY)) rx_pbit <= rx_s;
      end
    end
  end

  assign rx_pop = rx_valid && rx_ready;

  sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_push),
    .wr_data (rx_word),
    .rd_en   (rx_pop),
    .rd_data (rx_head),
    .full    (rx_fifo_full),
    .empty   (rx_fifo_empty)
  );

  assign rx_valid      = !rx_fifo_empty;
  assign rx_data       = rx_valid ? rx_head[7:0] : 8'h00;
  assign rx_frame_err  = rx_valid && rx_head[8];
  assign rx_parity_err = rx_valid && rx_head[9];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rx_overrun <= 1'b0;
    else if (rx_push && rx_fifo_full && !rx_pop)
      rx_overrun <= 1'b1;
    else if (err_clr)
      rx_overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core: frame-level reference model of the
// serial line, loopback and directly driven RX frames, FIFO corner cases.
module tb_uart_fifo_core;

  localparam int OS    = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  data_len;
  logic        parity_en, parity_odd, stop2;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_sn, tx_busy;
  logic        rx_sn, rx_drv, loop;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready, rx_frame_err, rx_parity_err, rx_overrun, err_clr;

  int checks = 0;
  int errors = 0;

  assign rx_sn = loop ? tx_sn : rx_drv;

  always #5 clk = ~clk;

  uart_fifo_core #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .data_len(data_len),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sn(tx_sn), .tx_busy(tx_busy), .rx_sn(rx_sn),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun), .err_clr(err_clr)
  );

  // ---------------- reference model and stimulus helpers ----------------
  function automatic logic [7:0] word_mask(input logic [1:0] len);
    return 8'((1 << (int'(len) + 5)) - 1);
  endfunction

  // Serial line image of one frame, bit 0 first; bad_par flips the parity bit
  task automatic build_frame(input logic [7:0] d, input logic [1:0] len, input logic pe,
                             input logic po, input logic s2, input logic bad_par,
                             output logic [11:0] bits, output int nb);
    int ones = 0;
    bits = '1;
    nb = 0;
    bits[nb] = 1'b0; nb = nb + 1;
    for (int i = 0; i < int'(len) + 5; i++) begin
      bits[nb] = d[i];
      ones = ones + int'(d[i]);
      nb = nb + 1;
    end
    if (pe) begin
      bits[nb] = 1'((ones % 2) ^ int'(po) ^ int'(bad_par));
      nb = nb + 1;
    end
    bits[nb] = 1'b1; nb = nb + 1;
    if (s2) begin bits[nb] = 1'b1; nb = nb + 1; end
  endtask

  task automatic set_cfg(input logic [15:0] bd, input logic [1:0] len, input logic pe,
                         input logic po, input logic s2);
    baud_div = bd; data_len = len; parity_en = pe; parity_odd = po; stop2 = s2;
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_tx_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (tx_sn === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (rx_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Called on the negedge of the first start-bit cycle; counts cycles whose
  // line level differs from the frame image
  task automatic capture_tx(input logic [11:0] bits, input int nb, input int p,
                            input bit scramble, output int bad, output int first);
    bad = 0;
    first = -1;
    for (int c = 0; c < nb * p; c++) begin
      if (c > 0) @(negedge clk);
      if (scramble && c == p) begin
        data_len = 2'($urandom); parity_en = 1'($urandom);
        parity_odd = 1'($urandom); stop2 = 1'($urandom);
      end
      if (tx_sn !== bits[c / p]) begin
        bad = bad + 1;
        if (first < 0) first = c;
      end
    end
  endtask

  task automatic drive_rx_frame(input logic [11:0] bits, input int nb, input int p,
                                input bit bad_stop);
    for (int i = 0; i < nb; i++) begin
      rx_drv = bits[i];
      if (bad_stop && i == nb - 1) begin
        rx_drv = 1'b0;
        repeat (3 * p / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (p - 3 * p / 4) @(negedge clk);
      end else begin
        repeat (p) @(negedge clk);
      end
    end
    rx_drv = 1'b1;
  endtask

  task automatic pop_rx;
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [14:0] obs;
    rst = 1'b1; loop = 1'b0; rx_drv = 1'b1; tx_valid = 1'b0; tx_data = '0;
    rx_ready = 1'b0; err_clr = 1'b0;
    set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    obs = {tx_sn, tx_busy, tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun};
    checks++;
    if (obs !== 15'b1_0_1_0_00000000_0_0_0) begin
      errors++;
      $display("FAIL reset_held: got %b want %b", obs, 15'b1_0_1_0_00000000_0_0_0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    obs = {tx_sn, tx_busy, tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun};
    checks++;
    if (obs !== 15'b1_0_1_0_00000000_0_0_0) begin
      errors++;
      $display("FAIL reset_released: got %b want %b", obs, 15'b1_0_1_0_00000000_0_0_0);
    end
  endtask

  task automatic test_tx_a5;
    logic [11:0] bits; int nb, bad, first; bit ok;
    loop = 1'b1;
    set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    build_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, bits, nb);
    write_tx(8'hA5);
    checks++;
    if (tx_sn !== 1'b1 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL a5_pop_cycle: tx_sn=%b tx_busy=%b want 1 1", tx_sn, tx_busy);
    end
    @(negedge clk);
    checks++;
    if (tx_sn !== 1'b0) begin
      errors++;
      $display("FAIL a5_start_latency: tx_sn=%b want 0 on cycle after pop", tx_sn);
    end
    capture_tx(bits, nb, OS, 1'b0, bad, first);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL a5_wave: %0d wrong cycles, first %0d, want 160-cycle pattern %b", bad, first, bits);
    end
    @(negedge clk);
    checks++;
    if (tx_sn !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL a5_after_frame: tx_sn=%b tx_busy=%b want 1 0", tx_sn, tx_busy);
    end
    wait_rx(ok);
    checks++;
    if (!ok || {rx_data, rx_frame_err, rx_parity_err} !== {8'hA5, 2'b00}) begin
      errors++;
      $display("FAIL a5_loopback: valid=%b data=%h fe=%b pe=%b want A5 0 0", rx_valid, rx_data, rx_frame_err, rx_parity_err);
    end
    pop_rx();
  endtask

  task automatic test_loopback_7e2;
    logic [11:0] bits; int nb, bad, first; bit ok;
    loop = 1'b1;
    set_cfg(16'd3, 2'd2, 1'b1, 1'b0, 1'b1);
    build_frame(8'h55, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, bits, nb);
    write_tx(8'h55);
    wait_tx_low(ok);
    capture_tx(bits, nb, OS * 4, 1'b0, bad, first);
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL 7e2_wave: started=%b wrong=%0d first=%0d want %0d-cycle pattern %b", ok, bad, first, nb * OS * 4, bits);
    end
    wait_rx(ok);
    checks++;
    if (!ok || {rx_data, rx_frame_err, rx_parity_err, rx_overrun} !== {8'h55, 3'b000}) begin
      errors++;
      $display("FAIL 7e2_rx: valid=%b data=%h fe=%b pe=%b ov=%b want 55 0 0 0", rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun);
    end
    pop_rx();
  endtask

  task automatic test_random_frames;
    logic [11:0] bits; int nb, bad, first; bit ok;
    logic [7:0] d; logic [1:0] len; logic pe, po, s2; logic [15:0] bd;
    loop = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bd = 16'($urandom_range(0, 2)); len = 2'($urandom); pe = 1'($urandom);
      po = 1'($urandom); s2 = 1'($urandom); d = 8'($urandom);
      set_cfg(bd, len, pe, po, s2);
      build_frame(d, len, pe, po, s2, 1'b0, bits, nb);
      write_tx(d);
      wait_tx_low(ok);
      capture_tx(bits, nb, OS * (int'(bd) + 1), 1'b1, bad, first);
      checks++;
      if (!ok || bad != 0) begin
        errors++;
        $display("FAIL rand_wave[%0d]: started=%b wrong=%0d first=%0d bd=%0d len=%0d pe=%b po=%b s2=%b d=%h",
                 k, ok, bad, first, bd, len, pe, po, s2, d);
      end
      wait_rx(ok);
      checks++;
      if (!ok || {rx_data, rx_frame_err, rx_parity_err} !== {d & word_mask(len), 2'b00}) begin
        errors++;
        $display("FAIL rand_rx[%0d]: valid=%b data=%h fe=%b pe=%b want %h 0 0",
                 k, rx_valid, rx_data, rx_frame_err, rx_parity_err, d & word_mask(len));
      end
      pop_rx();
    end
  endtask

  task automatic test_glitch;
    logic [11:0] bits; int nb; bit ok; logic [7:0] d;
    loop = 1'b0; rx_drv = 1'b1;
    set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (64) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_push: rx_valid=%b want 0", rx_valid);
    end
    d = 8'($urandom);
    build_frame(d, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, bits, nb);
    drive_rx_frame(bits, nb, OS, 1'b0);
    wait_rx(ok);
    checks++;
    if (!ok || {rx_data, rx_frame_err, rx_parity_err} !== {d, 2'b00}) begin
      errors++;
      $display("FAIL glitch_recover: valid=%b data=%h fe=%b pe=%b want %h 0 0", rx_valid, rx_data, rx_frame_err, rx_parity_err, d);
    end
    pop_rx();
  endtask

  task automatic test_errors;
    logic [11:0] bits; int nb; logic [7:0] d;
    loop = 1'b0; rx_drv = 1'b1;
    set_cfg(16'd0, 2'd2, 1'b1, 1'b0, 1'b0);
    d = 8'($urandom);
    build_frame(d, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, bits, nb);
    drive_rx_frame(bits, nb, OS, 1'b1);
    repeat (40) @(negedge clk);
    checks++;
    if ({rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun} !== {1'b1, d & 8'h7F, 3'b110}) begin
      errors++;
      $display("FAIL err_flags: valid=%b data=%h fe=%b pe=%b ov=%b want 1 %h 1 1 0",
               rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun, d & 8'h7F);
    end
    pop_rx();
    repeat (40) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_single_word: rx_valid=%b want 0 after one pop", rx_valid);
    end
  endtask

  task automatic test_overrun;
    logic [11:0] bits; int nb; logic [7:0] w [5];
    loop = 1'b0; rx_drv = 1'b1; rx_ready = 1'b0;
    set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      w[k] = 8'($urandom);
      build_frame(w[k], 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, bits, nb);
      drive_rx_frame(bits, nb, OS, 1'b0);
      repeat (4) @(negedge clk);
      if (k == 3) begin
        checks++;
        if (rx_overrun !== 1'b0 || rx_valid !== 1'b1) begin
          errors++;
          $display("FAIL ovr_before_full: ov=%b valid=%b want 0 1", rx_overrun, rx_valid);
        end
      end
    end
    checks++;
    if (rx_overrun !== 1'b1 || rx_data !== w[0]) begin
      errors++;
      $display("FAIL ovr_set: ov=%b head=%h want 1 %h", rx_overrun, rx_data, w[0]);
    end
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    checks++;
    if (rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: ov=%b want 0", rx_overrun);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== w[k]) begin
        errors++;
        $display("FAIL ovr_order[%0d]: valid=%b data=%h want 1 %h", k, rx_valid, rx_data, w[k]);
      end
      pop_rx();
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_drained: rx_valid=%b want 0", rx_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w [5]; int i; bit acc, ok;
    loop = 1'b1; rx_ready = 1'b0;
    set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) w[k] = 8'($urandom);
    i = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = w[0];
    for (int g = 0; g < 50 && i < 5; g++) begin
      acc = tx_ready;
      @(negedge clk);
      if (acc) begin
        i = i + 1;
        if (i < 5) tx_data = w[i];
      end
    end
    tx_valid = 1'b0;
    checks++;
    if (i != 5 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: accepted=%0d tx_ready=%b want 5 0", i, tx_ready);
    end
    for (int k = 0; k < 5; k++) begin
      wait_rx(ok);
      checks++;
      if (!ok || rx_data !== w[k]) begin
        errors++;
        $display("FAIL b2b_order[%0d]: valid=%b data=%h want %h", k, rx_valid, rx_data, w[k]);
      end
      pop_rx();
    end
    repeat (40) @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0 || tx_ready !== 1'b1 || rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b ready=%b ov=%b want 0 1 0", tx_busy, tx_ready, rx_overrun);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    loop = 1'b1; rx_ready = 1'b0;
    set_cfg(16'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    write_tx(8'h00);
    write_tx(8'h3C);
    wait_tx_low(ok);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (!ok || tx_sn !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: started=%b tx_sn=%b ready=%b busy=%b rx_valid=%b want 1 1 1 0 0",
               ok, tx_sn, tx_ready, tx_busy, rx_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || tx_sn !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_partial: rx_valid=%b tx_sn=%b busy=%b want 0 1 0", rx_valid, tx_sn, tx_busy);
    end
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_loopback_7e2();
    test_random_frames();
    test_glitch();
    test_errors();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
